// File: rtl/rom_serial_loader.sv
// 8N1 UART loader that streams a ROM image into storage at sequential addresses.
// Optional macro ROM_LOADER_INES_CHECK_EN validates the 4-byte iNES magic.
module rom_serial_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ROM_BYTES    = 'h6010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  input  logic        prg_ctrl,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] LAST    = 16'(ROM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t      state;
  state_t      state_n;
  logic        s1;
  logic        rx;
  logic        prg_q;
  logic        rise;
  logic        fall;
  logic        hit;
  logic        stop_hit;
  logic        frame_ok;
  logic        frame_bad;
  logic        hdr_bad;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic [15:0] counter;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b1;
      rx    <= 1'b1;
      prg_q <= 1'b0;
    end else begin
      s1    <= din;
      rx    <= s1;
      prg_q <= prg_ctrl;
    end
  end

  assign rise = prg_ctrl & ~prg_q;
  assign fall = ~prg_ctrl & prg_q;

  // Any session edge or an idle loader pins the receiver to IDLE,
  // which also discards a start bit already in flight.
  always_comb begin
    state_n  = state;
    stop_hit = 1'b0;
    hit      = (state == START) ? (cnt == HALF_M1) : (cnt == FULL_M1);
    if (rise || fall || !busy) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (!rx) state_n = START;
        START:   if (hit) state_n = rx ? IDLE : DATA;
        DATA:    if (hit && bit_idx == 3'd7) state_n = STOP;
        STOP: begin
          if (hit) begin
            state_n  = IDLE;
            stop_hit = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign frame_ok  = stop_hit & rx;
  assign frame_bad = stop_hit & ~rx;

`ifdef ROM_LOADER_INES_CHECK_EN
  logic [7:0] magic;
  always_comb begin
    magic = 8'h4E;
    case (counter[1:0])
      2'd0: magic = 8'h4E;
      2'd1: magic = 8'h45;
      2'd2: magic = 8'h53;
      2'd3: magic = 8'h1A;
      default: magic = 8'h4E;
    endcase
    hdr_bad = (counter < 16'd4) && (shreg != magic);
  end
`else
  assign hdr_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state <= state_n;
      if (state_n != state || hit || state == IDLE)
        cnt <= '0;
      else
        cnt <= cnt + 16'd1;
      if (state != DATA)
        bit_idx <= '0;
      else if (hit)
        bit_idx <= bit_idx + 3'd1;
      if (state == DATA && hit)
        shreg <= {rx, shreg[7:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      counter <= '0;
    end else begin
      wr_en <= 1'b0;
      if (rise) begin
        counter <= '0;
        done    <= 1'b0;
        err     <= 1'b0;
        busy    <= 1'b1;
      end else begin
        if (fall && busy) begin
          busy <= 1'b0;
        end else if (wr_en && wr_addr == LAST) begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        if (frame_bad)
          err <= 1'b1;
        if (frame_ok) begin
          if (hdr_bad) begin
            err  <= 1'b1;
            busy <= 1'b0;
          end else begin
            wr_en   <= 1'b1;
            wr_data <= shreg;
            wr_addr <= counter;
            counter <= counter + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rom_serial_loader.sv
// Randomized bench for rom_serial_loader against a byte-level session model.
// Build with ROM_LOADER_INES_CHECK_EN to also exercise the header check.
module tb_rom_serial_loader;

  localparam int CPB = 8;
  localparam int RB  = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din = 1'b1;
  logic        prg_ctrl = 1'b0;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [23:0] got[$];
  logic [23:0] exp[$];
  bit          m_active;
  bit          m_done;
  bit          m_err;
  int          m_count;
  logic        en_prev = 1'b0;

  rom_serial_loader #(
    .CLKS_PER_BIT(CPB),
    .ROM_BYTES(RB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .prg_ctrl(prg_ctrl),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      got.push_back({wr_addr, wr_data});
      checks++;
      if (en_prev) begin
        errors++;
        $display("FAIL wr_en_width got=2+ cycles required=1");
      end
    end
    en_prev = wr_en;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1);
  end

  function automatic void model_byte(input logic [7:0] b, input bit ok);
    logic [7:0] magic [4];
    magic = '{8'h4E, 8'h45, 8'h53, 8'h1A};
    if (!m_active) return;
    if (!ok) begin
      m_err = 1'b1;
      return;
    end
`ifdef ROM_LOADER_INES_CHECK_EN
    if (m_count < 4 && b != magic[m_count]) begin
      m_err = 1'b1;
      m_active = 1'b0;
      return;
    end
`endif
    exp.push_back({16'(m_count), b});
    m_count++;
    if (m_count == RB) begin
      m_active = 1'b0;
      m_done = 1'b1;
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit ok, input int gap);
    @(negedge clk) din = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      din = b[i];
      repeat (CPB) @(negedge clk);
    end
    din = ok;
    repeat (CPB) @(negedge clk);
    din = 1'b1;
    repeat (ok ? gap : gap + 12) @(negedge clk);
    model_byte(b, ok);
  endtask

  task automatic prg_rise();
    @(negedge clk) prg_ctrl = 1'b1;
    m_active = 1'b1;
    m_done = 1'b0;
    m_err = 1'b0;
    m_count = 0;
    exp.delete();
    got.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic prg_fall();
    @(negedge clk) prg_ctrl = 1'b0;
    m_active = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic cmp_session(input string tag);
    checks++;
    if (got.size() !== exp.size()) begin
      errors++;
      $display("FAIL %s_count got=%0d required=%0d", tag, got.size(), exp.size());
    end
    foreach (exp[i]) begin
      if (i < got.size()) begin
        checks++;
        if (got[i] !== exp[i]) begin
          errors++;
          $display("FAIL %s_write%0d got=%h required=%h", tag, i, got[i], exp[i]);
        end
      end
    end
    checks += 3;
    if (done !== m_done) begin
      errors++;
      $display("FAIL %s_done got=%b required=%b", tag, done, m_done);
    end
    if (busy !== m_active) begin
      errors++;
      $display("FAIL %s_busy got=%b required=%b", tag, busy, m_active);
    end
    if (err !== m_err) begin
      errors++;
      $display("FAIL %s_err got=%b required=%b", tag, err, m_err);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({wr_en, wr_addr, wr_data, busy, done, err} !== 28'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h required=0",
               {wr_en, wr_addr, wr_data, busy, done, err});
    end
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_normal_load();
    logic [7:0] img [6];
    img = '{8'h4E, 8'h45, 8'h53, 8'h1A, 8'hA5, 8'h3C};
    prg_rise();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL start_busy got=%b required=1", busy);
    end
    foreach (img[i]) send_byte(img[i], 1'b1, 2);
    cmp_session("normal");
  endtask

  task automatic test_after_done();
    send_byte(8'($urandom), 1'b1, 3);
    cmp_session("after_done");
  endtask

  task automatic test_framing();
    prg_fall();
    prg_rise();
    send_byte(8'h55, 1'b0, 2);
    send_byte(8'h77, 1'b1, 2);
    cmp_session("framing");
  endtask

  task automatic test_glitch();
    prg_fall();
    prg_rise();
    @(negedge clk) din = 1'b0;
    repeat (2) @(negedge clk);
    din = 1'b1;
    repeat (20) @(negedge clk);
    cmp_session("glitch");
    send_byte(8'h12, 1'b1, 2);
    cmp_session("glitch_next");
  endtask

  task automatic test_abort();
    prg_fall();
    prg_rise();
    send_byte(8'h99, 1'b0, 2);
    send_byte(8'h4E, 1'b1, 2);
    send_byte(8'h45, 1'b1, 2);
    send_byte(8'h53, 1'b1, 2);
    prg_fall();
    cmp_session("abort");
    checks++;
    if (wr_addr !== 16'd2) begin
      errors++;
      $display("FAIL abort_addr_hold got=%0d required=2", wr_addr);
    end
    prg_rise();
    cmp_session("restart");
    send_byte(8'hFF, 1'b1, 2);
    cmp_session("restart_byte");
  endtask

  task automatic test_reset_mid();
    prg_fall();
    prg_rise();
    send_byte(8'h4E, 1'b1, 2);
    send_byte(8'h45, 1'b1, 2);
    checks++;
    if (wr_addr !== 16'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst got=addr%0d/busy%b required=addr1/busy1", wr_addr, busy);
    end
    @(negedge clk) din = 1'b0;
    repeat (CPB + 2 * CPB) @(negedge clk);
    din = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({wr_en, wr_addr, wr_data, busy, done, err} !== 28'd0) begin
      errors++;
      $display("FAIL async_reset got=%h required=0",
               {wr_en, wr_addr, wr_data, busy, done, err});
    end
    prg_ctrl = 1'b0;
    din = 1'b1;
    m_active = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    prg_rise();
    send_byte(8'h4E, 1'b1, 2);
    cmp_session("post_reset");
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      prg_fall();
      prg_rise();
      for (int k = 0; k < 9; k++)
        send_byte(8'($urandom), $urandom_range(0, 4) != 0, $urandom_range(1, 6));
      cmp_session("random");
    end
  endtask

`ifdef ROM_LOADER_INES_CHECK_EN
  task automatic test_ines();
    prg_fall();
    prg_rise();
    send_byte(8'h4E, 1'b1, 2);
    send_byte(8'h46, 1'b1, 2);
    cmp_session("ines");
  endtask
`endif

  initial begin
    test_reset();
    test_normal_load();
    test_after_done();
    test_framing();
    test_glitch();
    test_abort();
    test_reset_mid();
    test_random();
`ifdef ROM_LOADER_INES_CHECK_EN
    test_ines();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
